// File: rtl/mem_arb_pkg.sv
// Shared definitions for the CPU / program-loader memory arbiter.
//   arb_state_e : arbiter FSM states (IDLE -> ACC -> DONE)
//   OWN_CPU/LD  : owner encoding driven on the owner output
//   BURST_W     : width of the loader burst counter (MAX_BURST up to 15)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_LD  = 1'b1;

  localparam int unsigned BURST_W = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the memory array.
//   CPU port    : cpu_req/cpu_we/cpu_addr/cpu_wdata in, cpu_rdata/cpu_ack out
//   Loader port : ld_req/ld_we/ld_addr/ld_wdata/ld_lock in, ld_rdata/ld_ack out
//   Memory port : mem_we/mem_addr/mem_wdata out, mem_rdata in (async read)
//   owner       : 0 = CPU, 1 = loader; owner of current/last access
// slave  = arbiter view, master = requesters + memory view.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) ();

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;

  logic              ld_req;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic [DATA_W-1:0] ld_rdata;
  logic              ld_ack;
  logic              ld_lock;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              owner;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack,
    input  ld_req, ld_we, ld_addr, ld_wdata, ld_lock,
    output ld_rdata, ld_ack,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output owner
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack,
    output ld_req, ld_we, ld_addr, ld_wdata, ld_lock,
    input  ld_rdata, ld_ack,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  owner
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select for the memory arbiter.
//   cpu_elig_i   : CPU request eligible (cpu_req && !ld_lock)
//   ld_elig_i    : loader request eligible
//   last_owner_i : owner of the previous grant (round-robin tie-break)
//   burst_cnt_i  : consecutive loader grants while the CPU is waiting
//   grant_o      : some requester is eligible
//   winner_o     : OWN_CPU / OWN_LD
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned LD_PRIO   = 0,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic               cpu_elig_i,
  input  logic               ld_elig_i,
  input  logic               last_owner_i,
  input  logic [BURST_W-1:0] burst_cnt_i,
  output logic               grant_o,
  output logic               winner_o
);

  localparam logic [BURST_W-1:0] MAX_B = BURST_W'(MAX_BURST);

  always_comb begin
    grant_o  = cpu_elig_i | ld_elig_i;
    winner_o = OWN_CPU;
    if (LD_PRIO != 0) begin
      // Loader wins unless its burst allowance is used up and the CPU can go.
      if (ld_elig_i && !(cpu_elig_i && (burst_cnt_i == MAX_B))) begin
        winner_o = OWN_LD;
      end
    end else begin
      if (cpu_elig_i && ld_elig_i) begin
        winner_o = ~last_owner_i;
      end else if (ld_elig_i) begin
        winner_o = OWN_LD;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing the single data/program memory between the CPU and the
// program-loader port. Registered req/ack handshake: a request sampled at
// edge T0 is driven to memory during T0..T1 and acknowledged during T1..T2.
//   clk : clock, all state on posedge
//   rst : asynchronous, active-low reset
//   bus : mem_arbiter_if.slave (CPU port, loader port, memory port, owner)
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned LD_PRIO   = 0,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam logic [BURST_W-1:0] MAX_B = BURST_W'(MAX_BURST);

  arb_state_e         state_q, state_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic               owner_q, owner_d;
  logic               last_owner_q, last_owner_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic               cpu_ack_q, cpu_ack_d;
  logic               ld_ack_q, ld_ack_d;
  logic [DATA_W-1:0]  cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]  ld_rdata_q, ld_rdata_d;

  logic cpu_elig, ld_elig;
  logic pick_grant, pick_winner;
  logic start;

  assign cpu_elig = bus.cpu_req & ~bus.ld_lock;
  assign ld_elig  = bus.ld_req;

  mem_arb_pick #(
    .LD_PRIO   (LD_PRIO),
    .MAX_BURST (MAX_BURST)
  ) u_pick (
    .cpu_elig_i   (cpu_elig),
    .ld_elig_i    (ld_elig),
    .last_owner_i (last_owner_q),
    .burst_cnt_i  (burst_q),
    .grant_o      (pick_grant),
    .winner_o     (pick_winner)
  );

  always_comb begin
    state_d      = state_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    burst_d      = bus.cpu_req ? burst_q : '0;
    cpu_ack_d    = 1'b0;
    ld_ack_d     = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    ld_rdata_d   = ld_rdata_q;
    start        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_grant) begin
          start = 1'b1;
        end
      end
      ST_ACC: begin
        mem_we_d = 1'b0;
        if (owner_q == OWN_LD) begin
          ld_rdata_d = bus.mem_rdata;
          ld_ack_d   = 1'b1;
        end else begin
          cpu_rdata_d = bus.mem_rdata;
          cpu_ack_d   = 1'b1;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        // The pick runs on the full eligible set so priority and burst rules
        // still apply, but only a win by the other requester is granted here;
        // the current owner's request is never re-granted back to back.
        if (pick_grant && (pick_winner != owner_q)) begin
          start = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (start) begin
      state_d      = ST_ACC;
      owner_d      = pick_winner;
      last_owner_d = pick_winner;
      if (pick_winner == OWN_LD) begin
        mem_we_d    = bus.ld_we;
        mem_addr_d  = bus.ld_addr;
        mem_wdata_d = bus.ld_wdata;
        if (!bus.cpu_req) begin
          burst_d = '0;
        end else if (burst_q != MAX_B) begin
          burst_d = burst_q + BURST_W'(1);
        end
      end else begin
        mem_we_d    = bus.cpu_we;
        mem_addr_d  = bus.cpu_addr;
        mem_wdata_d = bus.cpu_wdata;
        burst_d     = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      owner_q      <= OWN_CPU;
      last_owner_q <= OWN_LD;
      burst_q      <= '0;
      cpu_ack_q    <= 1'b0;
      ld_ack_q     <= 1'b0;
      cpu_rdata_q  <= '0;
      ld_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      burst_q      <= burst_d;
      cpu_ack_q    <= cpu_ack_d;
      ld_ack_q     <= ld_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
      ld_rdata_q   <= ld_rdata_d;
    end
  end

  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.owner     = owner_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.ld_ack    = ld_ack_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.ld_rdata  = ld_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a round-robin instance exercised with directed and
// random accesses against a word-array reference model, and a loader-priority
// instance checked for the burst grant pattern.
module tb_mem_arbiter;

  localparam int unsigned MAXB = 4;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(4), .DATA_W(8)) bus_rr ();
  mem_arbiter_if #(.ADDR_W(4), .DATA_W(8)) bus_bp ();

  mem_arbiter #(.ADDR_W(4), .DATA_W(8), .LD_PRIO(0), .MAX_BURST(MAXB)) u_rr (
    .clk (clk),
    .rst (rst_n),
    .bus (bus_rr)
  );

  mem_arbiter #(.ADDR_W(4), .DATA_W(8), .LD_PRIO(1), .MAX_BURST(MAXB)) u_bp (
    .clk (clk),
    .rst (rst_n),
    .bus (bus_bp)
  );

  // Memory arrays: async read, write on posedge.
  logic [7:0] mem_rr [16];
  logic [7:0] mem_bp [16];

  always @(posedge clk) begin
    if (bus_rr.mem_we) mem_rr[bus_rr.mem_addr] <= bus_rr.mem_wdata;
    if (bus_bp.mem_we) mem_bp[bus_bp.mem_addr] <= bus_bp.mem_wdata;
  end

  assign bus_rr.mem_rdata = mem_rr[bus_rr.mem_addr];
  assign bus_bp.mem_rdata = mem_bp[bus_bp.mem_addr];

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state (index 0 = CPU, 1 = loader).
  logic [7:0] ref_mem [16];
  bit         last_ld;
  logic [7:0] exp_rd    [2];
  bit         exp_rd_ok [2];

  bit lock_window = 1'b0;
  int lock_acks   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("rr_acks_exclusive", 32'(bus_rr.cpu_ack & bus_rr.ld_ack), 32'd0);
      check("bp_acks_exclusive", 32'(bus_bp.cpu_ack & bus_bp.ld_ack), 32'd0);
      if (lock_window && bus_rr.cpu_ack) lock_acks++;
    end
  end

  task automatic drive(input bit is_ld, input bit req, input bit we,
                       input logic [3:0] a, input logic [7:0] d);
    if (is_ld) begin
      bus_rr.ld_req = req; bus_rr.ld_we = we; bus_rr.ld_addr = a; bus_rr.ld_wdata = d;
    end else begin
      bus_rr.cpu_req = req; bus_rr.cpu_we = we; bus_rr.cpu_addr = a; bus_rr.cpu_wdata = d;
    end
  endtask

  function automatic logic acked(input bit is_ld);
    return is_ld ? bus_rr.ld_ack : bus_rr.cpu_ack;
  endfunction

  function automatic logic [7:0] rdata_of(input bit is_ld);
    return is_ld ? bus_rr.ld_rdata : bus_rr.cpu_rdata;
  endfunction

  // Effect of one served access on the model: reads return the word as it
  // stood before the access, writes update it.
  task automatic model_access(input bit is_ld, input bit we,
                              input logic [3:0] a, input logic [7:0] d);
    if (we) begin
      ref_mem[a]       = d;
      exp_rd_ok[is_ld] = 1'b0;
    end else begin
      exp_rd[is_ld]    = ref_mem[a];
      exp_rd_ok[is_ld] = 1'b1;
    end
    last_ld = is_ld;
  endtask

  task automatic check_rdata(input string tag);
    if (exp_rd_ok[0]) check({tag, "_cpu_rdata"}, 32'(bus_rr.cpu_rdata), 32'(exp_rd[0]));
    if (exp_rd_ok[1]) check({tag, "_ld_rdata"},  32'(bus_rr.ld_rdata),  32'(exp_rd[1]));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_cpu_ack"},   32'(bus_rr.cpu_ack),   32'd0);
    check({tag, "_ld_ack"},    32'(bus_rr.ld_ack),    32'd0);
    check({tag, "_mem_we"},    32'(bus_rr.mem_we),    32'd0);
    check({tag, "_mem_addr"},  32'(bus_rr.mem_addr),  32'd0);
    check({tag, "_mem_wdata"}, 32'(bus_rr.mem_wdata), 32'd0);
    check({tag, "_cpu_rdata"}, 32'(bus_rr.cpu_rdata), 32'd0);
    check({tag, "_ld_rdata"},  32'(bus_rr.ld_rdata),  32'd0);
    check({tag, "_owner"},     32'(bus_rr.owner),     32'd0);
  endtask

  task automatic single(input bit is_ld, input bit we, input logic [3:0] a,
                        input logic [7:0] d, input string tag);
    int lat;
    @(negedge clk);
    drive(is_ld, 1'b1, we, a, d);
    lat = 99;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (acked(is_ld)) begin
        lat = c;
        break;
      end
    end
    model_access(is_ld, we, a, d);
    check({tag, "_latency"}, 32'(lat), 32'd2);
    check({tag, "_owner"}, 32'(bus_rr.owner), 32'(is_ld));
    check_rdata(tag);
    drive(is_ld, 1'b0, we, a, d);
  endtask

  // Both requesters raise req on the same cycle: the one not served last goes
  // first (ack after 2 cycles), the other follows directly (ack after 4).
  task automatic pair(input bit cwe, input logic [3:0] ca, input logic [7:0] cd,
                      input bit lwe, input logic [3:0] la, input logic [7:0] ld,
                      input string tag);
    bit         we  [2];
    logic [3:0] a   [2];
    logic [7:0] d   [2];
    int         lat [2];
    logic [7:0] rd  [2];
    bit         first;
    we[0] = cwe; a[0] = ca; d[0] = cd;
    we[1] = lwe; a[1] = la; d[1] = ld;
    lat[0] = 99; lat[1] = 99;
    rd[0] = '0;  rd[1] = '0;
    first = !last_ld;
    @(negedge clk);
    drive(1'b0, 1'b1, we[0], a[0], d[0]);
    drive(1'b1, 1'b1, we[1], a[1], d[1]);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      for (int r = 0; r < 2; r++) begin
        if (lat[r] == 99 && acked(r[0])) begin
          lat[r] = c;
          rd[r]  = rdata_of(r[0]);
          drive(r[0], 1'b0, we[r], a[r], d[r]);
        end
      end
      if (lat[0] != 99 && lat[1] != 99) break;
    end
    drive(1'b0, 1'b0, we[0], a[0], d[0]);
    drive(1'b1, 1'b0, we[1], a[1], d[1]);
    model_access(first, we[first], a[first], d[first]);
    model_access(!first, we[!first], a[!first], d[!first]);
    check({tag, "_first_latency"},  32'(lat[first]),  32'd2);
    check({tag, "_second_latency"}, 32'(lat[!first]), 32'd4);
    for (int r = 0; r < 2; r++) begin
      if (exp_rd_ok[r]) check({tag, "_rdata_at_ack"}, 32'(rd[r]), 32'(exp_rd[r]));
    end
    check_rdata(tag);
  endtask

  initial begin
    int         lat;
    int         got;
    bit         order [10];
    logic [3:0] ra, rb;
    logic [7:0] da, db;
    int unsigned kind;

    rst_n = 1'b1;
    bus_rr.ld_lock = 1'b0;
    bus_bp.ld_lock = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    drive(1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
    bus_bp.cpu_req = 1'b0; bus_bp.cpu_we = 1'b0; bus_bp.cpu_addr = '0; bus_bp.cpu_wdata = '0;
    bus_bp.ld_req  = 1'b0; bus_bp.ld_we  = 1'b0; bus_bp.ld_addr  = '0; bus_bp.ld_wdata  = '0;
    for (int i = 0; i < 16; i++) begin
      mem_rr[i]  = '0;
      mem_bp[i]  = '0;
      ref_mem[i] = '0;
    end
    last_ld = 1'b1;
    exp_rd[0] = '0; exp_rd[1] = '0;
    exp_rd_ok[0] = 1'b1; exp_rd_ok[1] = 1'b1;

    #1 rst_n = 1'b0;
    #2 check_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Simultaneous requests straight after reset: CPU first, loader next.
    pair(1'b1, 4'd1, 8'h5A, 1'b1, 4'd2, 8'h77, "tie_after_reset");

    // CPU write then read back.
    single(1'b0, 1'b1, 4'd3, 8'hA5, "cpu_wr3");
    single(1'b0, 1'b0, 4'd3, 8'h00, "cpu_rd3");

    // CPU writes 0xFF at 15, reads it, then the loader reads it back.
    single(1'b0, 1'b1, 4'd15, 8'hFF, "t6_cpu_wr");
    single(1'b0, 1'b0, 4'd15, 8'h00, "t6_cpu_rd");
    single(1'b1, 1'b0, 4'd15, 8'h00, "t6_ld_rd");

    // Random mix of single and simultaneous accesses.
    for (int i = 0; i < 30; i++) begin
      kind = $urandom_range(0, 2);
      ra = 4'($urandom); rb = 4'($urandom);
      da = 8'($urandom); db = 8'($urandom);
      case (kind)
        0:       single(1'b0, 1'($urandom), ra, da, "rnd_cpu");
        1:       single(1'b1, 1'($urandom), ra, da, "rnd_ld");
        default: pair(1'($urandom), ra, da, 1'($urandom), rb, db, "rnd_pair");
      endcase
    end

    // Bulk load under ld_lock while the CPU waits on addr 15.
    @(negedge clk);
    bus_rr.ld_lock = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 4'd15, 8'h00);
    lock_acks   = 0;
    lock_window = 1'b1;
    for (int i = 0; i < 16; i++) begin
      single(1'b1, 1'b1, 4'(i), 8'($urandom), "lock_load");
    end
    lock_window = 1'b0;
    check("lock_no_cpu_ack", 32'(lock_acks), 32'd0);
    bus_rr.ld_lock = 1'b0;
    lat = 99;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus_rr.cpu_ack) begin
        lat = c;
        break;
      end
    end
    model_access(1'b0, 1'b0, 4'd15, 8'h00);
    check("unlock_cpu_latency", 32'(lat), 32'd2);
    check_rdata("unlock_cpu_rd15");
    drive(1'b0, 1'b0, 1'b0, 4'd15, 8'h00);

    // Reset during the ACC cycle of a write.
    single(1'b0, 1'b1, 4'd7, 8'h11, "pre_rst_wr7");
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 4'd7, 8'h3C);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("mid_acc_reset");
    drive(1'b0, 1'b0, 1'b1, 4'd7, 8'h3C);
    repeat (2) @(negedge clk);
    check("mid_acc_reset_mem7", 32'(mem_rr[7]), 32'(ref_mem[7]));
    rst_n = 1'b1;
    last_ld = 1'b1;
    exp_rd[0] = '0; exp_rd[1] = '0;
    exp_rd_ok[0] = 1'b1; exp_rd_ok[1] = 1'b1;
    single(1'b0, 1'b0, 4'd7, 8'h00, "post_rst_rd7");

    // Loader priority: both held, every (MAXB+1)-th grant goes to the CPU.
    @(negedge clk);
    bus_bp.cpu_req = 1'b1; bus_bp.cpu_addr = 4'd0;
    bus_bp.ld_req  = 1'b1; bus_bp.ld_addr  = 4'd1;
    got = 0;
    for (int i = 0; i < 10; i++) order[i] = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (got < 10 && bus_bp.cpu_ack) begin order[got] = 1'b0; got++; end
      if (got < 10 && bus_bp.ld_ack)  begin order[got] = 1'b1; got++; end
      if (got == 10) break;
    end
    bus_bp.cpu_req = 1'b0;
    bus_bp.ld_req  = 1'b0;
    check("burst_grant_count", 32'(got), 32'd10);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("burst_grant_%0d", i), 32'(order[i]),
            32'(((i % (MAXB + 1)) == MAXB) ? 0 : 1));
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
